// File: rtl/adc_sar_controller.sv
// Successive-approximation sequencer for a 12-bit capacitive DAC.
// Runs sample/settle/compare per bit and averages 2^N conversions.
module adc_sar_controller #(
    parameter int unsigned SAMPLE_CNT_W = 4,
    parameter int unsigned ACC_W        = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    start_in,
    input  logic [SAMPLE_CNT_W-1:0] sample_cycles_in,
    input  logic [2:0]              avg_log2_in,
    input  logic                    comp_in,
    output logic [11:0]             dac_data_out,
    output logic                    sample_out,
    output logic                    comp_strobe_out,
    output logic                    busy_out,
    output logic [11:0]             result_out,
    output logic                    result_valid_out
);

    localparam int unsigned DAC_W  = 12;
    localparam int unsigned CONV_W = 5;
    localparam int unsigned BIT_W  = 4;
    localparam logic [DAC_W-1:0] MID_CODE = 12'h800;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        COMPARE,
        ACCUM
    } state_t;

    state_t                  state_q, state_d;
    logic [SAMPLE_CNT_W-1:0] samp_cfg_q, samp_cfg_d;
    logic [SAMPLE_CNT_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [2:0]              avg_q, avg_d;
    logic [BIT_W-1:0]        bit_idx_q, bit_idx_d;
    logic [DAC_W-1:0]        code_q, code_d;
    logic [ACC_W-1:0]        acc_q, acc_d, acc_sum;
    logic [CONV_W-1:0]       conv_cnt_q, conv_cnt_d;
    logic [DAC_W-1:0]        dac_d, result_d;
    logic                    sample_d, strobe_d, busy_d, valid_d;

    // State and registered outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q          <= IDLE;
            samp_cfg_q       <= '0;
            samp_cnt_q       <= '0;
            avg_q            <= '0;
            bit_idx_q        <= '0;
            code_q           <= '0;
            acc_q            <= '0;
            conv_cnt_q       <= '0;
            dac_data_out     <= MID_CODE;
            sample_out       <= 1'b0;
            comp_strobe_out  <= 1'b0;
            busy_out         <= 1'b0;
            result_out       <= '0;
            result_valid_out <= 1'b0;
        end else begin
            state_q          <= state_d;
            samp_cfg_q       <= samp_cfg_d;
            samp_cnt_q       <= samp_cnt_d;
            avg_q            <= avg_d;
            bit_idx_q        <= bit_idx_d;
            code_q           <= code_d;
            acc_q            <= acc_d;
            conv_cnt_q       <= conv_cnt_d;
            dac_data_out     <= dac_d;
            sample_out       <= sample_d;
            comp_strobe_out  <= strobe_d;
            busy_out         <= busy_d;
            result_out       <= result_d;
            result_valid_out <= valid_d;
        end
    end

    // Next state, datapath and output decode
    always_comb begin
        state_d    = state_q;
        samp_cfg_d = samp_cfg_q;
        samp_cnt_d = samp_cnt_q;
        avg_d      = avg_q;
        bit_idx_d  = bit_idx_q;
        code_d     = code_q;
        acc_d      = acc_q;
        conv_cnt_d = conv_cnt_q;
        result_d   = result_out;
        valid_d    = 1'b0;
        acc_sum    = acc_q + ACC_W'(code_q);

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    samp_cfg_d = sample_cycles_in;
                    avg_d      = (avg_log2_in > 3'd4) ? 3'd4 : avg_log2_in;
                    acc_d      = '0;
                    conv_cnt_d = '0;
                    samp_cnt_d = '0;
                    state_d    = SAMPLE;
                end
            end
            SAMPLE: begin
                if (samp_cnt_q == samp_cfg_q) begin
                    bit_idx_d = BIT_W'(11);
                    code_d    = MID_CODE;
                    state_d   = SETTLE;
                end else begin
                    samp_cnt_d = samp_cnt_q + SAMPLE_CNT_W'(1);
                end
            end
            SETTLE: begin
                state_d = COMPARE;
            end
            COMPARE: begin
                // code_q already carries the trial bit; drop it on a low decision
                if (!comp_in) begin
                    code_d = code_q & ~(DAC_W'(1) << bit_idx_q);
                end
                if (bit_idx_q != '0) begin
                    code_d    = code_d | (DAC_W'(1) << (bit_idx_q - BIT_W'(1)));
                    bit_idx_d = bit_idx_q - BIT_W'(1);
                    state_d   = SETTLE;
                end else begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d      = acc_sum;
                conv_cnt_d = conv_cnt_q + CONV_W'(1);
                if (conv_cnt_d == (CONV_W'(1) << avg_q)) begin
                    result_d = DAC_W'(acc_sum >> avg_q);
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    samp_cnt_d = '0;
                    state_d    = SAMPLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sample_d = (state_d == SAMPLE);
        strobe_d = (state_d == COMPARE);
        busy_d   = (state_d != IDLE);
        dac_d    = (state_d == SETTLE || state_d == COMPARE || state_d == ACCUM) ? code_d : MID_CODE;
    end

endmodule

// File: tb/tb_adc_sar_controller.sv
// Scoreboarded bench for adc_sar_controller with an ideal comparator model.
module tb_adc_sar_controller;

    logic        clk_in;
    logic        rst_n_in;
    logic        start_in;
    logic [3:0]  sample_cycles_in;
    logic [2:0]  avg_log2_in;
    logic        comp_in;
    logic [11:0] dac_data_out;
    logic        sample_out;
    logic        comp_strobe_out;
    logic        busy_out;
    logic [11:0] result_out;
    logic        result_valid_out;

    logic [11:0] vin;
    logic [11:0] exp_q[$];
    logic [11:0] vals_q[$];
    int          checks = 0;
    int          errors = 0;

    adc_sar_controller #(.SAMPLE_CNT_W(4), .ACC_W(16)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .start_in         (start_in),
        .sample_cycles_in (sample_cycles_in),
        .avg_log2_in      (avg_log2_in),
        .comp_in          (comp_in),
        .dac_data_out     (dac_data_out),
        .sample_out       (sample_out),
        .comp_strobe_out  (comp_strobe_out),
        .busy_out         (busy_out),
        .result_out       (result_out),
        .result_valid_out (result_valid_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    assign comp_in = (vin >= dac_data_out);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every result pulse pops one expected value
    always @(negedge clk_in) begin
        if (rst_n_in === 1'b1 && result_valid_out === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_valid", 32'(result_valid_out), 32'd0);
            else                   check("result", 32'(result_out), 32'(exp_q.pop_front()));
        end
    end

    task automatic run_conv(input logic [3:0] s, input logic [2:0] avg,
                            input bit glitch, input bit hold_end, input bit prestarted);
        int          n, nconv, cyc, k, gaps, samp_cnt, strb_cnt, dac_bad, mbit;
        logic [31:0] sum;
        logic [11:0] mcode, trial;
        bit          done, prev_samp;
        n     = (avg > 3'd4) ? 4 : int'(avg);
        nconv = 1 << n;
        sum   = 32'd0;
        for (int i = 0; i < nconv; i++) sum += 32'(vals_q[i % vals_q.size()]);
        exp_q.push_back(12'(sum >> n));
        if (!prestarted) @(negedge clk_in);
        sample_cycles_in = s;
        avg_log2_in      = avg;
        start_in         = 1'b1;
        cyc = 0; k = 0; gaps = 0; samp_cnt = 0; strb_cnt = 0; dac_bad = 0;
        mbit = 11; mcode = '0; done = 1'b0; prev_samp = 1'b0;
        while (!done && cyc < 2000) begin
            @(negedge clk_in);
            cyc++;
            if (cyc == 1 || (glitch && cyc == 7)) start_in = 1'b0;
            if (glitch && cyc == 6) start_in = 1'b1;
            if (result_valid_out === 1'b1) begin
                done = 1'b1;
                check("busy_at_valid", 32'(busy_out), 32'd0);
                if (hold_end) start_in = 1'b1;
            end else begin
                if (busy_out !== 1'b1) gaps++;
                if (sample_out === 1'b1 && !prev_samp) begin
                    vin   = vals_q[k % vals_q.size()];
                    k++;
                    mcode = '0;
                    mbit  = 11;
                end
                if (sample_out === 1'b1) begin
                    samp_cnt++;
                    if (dac_data_out !== 12'h800) dac_bad++;
                end
                if (comp_strobe_out === 1'b1) begin
                    trial = mcode | (12'(1) << mbit);
                    if (dac_data_out !== trial) dac_bad++;
                    if (vin >= trial) mcode = trial;
                    mbit--;
                    strb_cnt++;
                end
            end
            prev_samp = sample_out;
        end
        check("timeout", 32'(done), 32'd1);
        check("latency", 32'(cyc), 32'(nconv * (int'(s) + 26) + 1));
        check("busy_gaps", 32'(gaps), 32'd0);
        check("sample_cycles", 32'(samp_cnt), 32'(nconv * (int'(s) + 1)));
        check("strobes", 32'(strb_cnt), 32'(nconv * 12));
        check("dac_trials", 32'(dac_bad), 32'd0);
        check("conversions", 32'(k), 32'(nconv));
    endtask

    initial begin
        int strobes, cyc, valids;
        rst_n_in = 1'b0; start_in = 1'b0; sample_cycles_in = '0; avg_log2_in = '0; vin = '0;
        repeat (3) @(negedge clk_in);
        check("rst_dac", 32'(dac_data_out), 32'h800);
        check("rst_sample", 32'(sample_out), 32'd0);
        check("rst_strobe", 32'(comp_strobe_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_valid", 32'(result_valid_out), 32'd0);
        check("rst_result", 32'(result_out), 32'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        vals_q = '{12'h5A3};        run_conv(4'd2, 3'd0, 1'b0, 1'b0, 1'b0);
        vals_q = '{12'h000};        run_conv(4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        vals_q = '{12'hFFF};        run_conv(4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        vals_q = '{12'h100, 12'h103}; run_conv(4'd1, 3'd2, 1'b0, 1'b0, 1'b0);
        vals_q = '{12'hABC};        run_conv(4'd0, 3'd7, 1'b0, 1'b0, 1'b0);
        vals_q = '{12'h5A3};        run_conv(4'd2, 3'd0, 1'b1, 1'b1, 1'b0);
        vals_q = '{12'h2C7};        run_conv(4'd2, 3'd0, 1'b0, 1'b0, 1'b1);

        // Abort during the bit-6 compare
        vals_q = '{12'h5A3};
        vin = 12'h5A3;
        exp_q.push_back(12'h5A3);
        @(negedge clk_in);
        sample_cycles_in = 4'd0; avg_log2_in = 3'd0; start_in = 1'b1;
        strobes = 0; cyc = 0;
        while (strobes < 6 && cyc < 200) begin
            @(negedge clk_in);
            cyc++;
            start_in = 1'b0;
            if (comp_strobe_out === 1'b1) strobes++;
        end
        check("reach_bit6", 32'(strobes), 32'd6);
        rst_n_in = 1'b0;
        #1;
        exp_q.delete();
        check("abort_dac", 32'(dac_data_out), 32'h800);
        check("abort_strobe", 32'(comp_strobe_out), 32'd0);
        check("abort_busy", 32'(busy_out), 32'd0);
        check("abort_result", 32'(result_out), 32'd0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        valids = 0;
        repeat (40) begin
            @(negedge clk_in);
            if (result_valid_out === 1'b1) valids++;
        end
        check("abort_no_valid", 32'(valids), 32'd0);
        vals_q = '{12'h3E9};        run_conv(4'd3, 3'd1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk_in);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
